// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_ADJUST = 2'd3
    } state_e;

endpackage

// File: rtl/bcd60_counter.sv
// Two-digit BCD counter 00..MAX with clear, increment and wrap carry.
module bcd60_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               carry_out
);

    localparam logic [DIGIT_W-1:0] TENS_MAX = DIGIT_W'(MAX / 10);
    localparam logic [DIGIT_W-1:0] ONES_MAX = DIGIT_W'(MAX % 10);
    localparam logic [DIGIT_W-1:0] NINE     = DIGIT_W'(9);

    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic               at_max;

    // Next-value logic: clear beats increment; wrap at MAX back to 00.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        at_max = (tens_q == TENS_MAX) && (ones_q == ONES_MAX);
        if (clr) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc) begin
            if (at_max) begin
                tens_d = '0;
                ones_d = '0;
            end else if (ones_q == NINE) begin
                ones_d = '0;
                tens_d = tens_q + DIGIT_W'(1);
            end else begin
                ones_d = ones_q + DIGIT_W'(1);
            end
        end
    end

    // Digit registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens      = tens_q;
    assign ones      = ones_q;
    assign carry_out = inc && !clr && at_max;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/pause/adjust FSM, button edge detect, blink mask.
module stopwatch_ctrl
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               tick_5hz,
    input  logic               btn_pause,
    input  logic               btn_clear,
    input  logic               sw_adj,
    input  logic               sw_sel,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [1:0]         state,
    output logic [1:0]         show_mask
);

    state_e     state_q, state_d;
    logic       btn_pause_q, btn_clear_q;
    logic       blink_q, blink_d;
    logic [1:0] show_mask_q, show_mask_d;

    logic       pause_edge, clear_edge;
    logic       sec_inc, min_inc;
    logic       sec_carry, sec_carry_gated;

    assign pause_edge = btn_pause & ~btn_pause_q;
    assign clear_edge = btn_clear & ~btn_clear_q;

    // Next state, counter controls, blink flag and display mask.
    always_comb begin
        state_d         = state_q;
        blink_d         = blink_q;
        show_mask_d     = 2'b11;
        sec_inc         = 1'b0;
        min_inc         = 1'b0;
        sec_carry_gated = sec_carry & (state_q != ST_ADJUST);

        if (clear_edge) begin
            state_d = sw_adj ? ST_ADJUST : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sw_adj)          state_d = ST_ADJUST;
                    else if (pause_edge) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (sw_adj) begin
                        state_d = ST_ADJUST;
                    end else begin
                        sec_inc = tick_1hz;
                        min_inc = sec_carry_gated;
                        if (pause_edge) state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (sw_adj)          state_d = ST_ADJUST;
                    else if (pause_edge) state_d = ST_RUN;
                end
                ST_ADJUST: begin
                    if (!sw_adj) state_d = ST_PAUSE;
                    sec_inc = tick_5hz & sw_sel;
                    min_inc = tick_5hz & ~sw_sel;
                    if (tick_2hz) blink_d = ~blink_q;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Entering adjust always starts with the selected field visible.
        if (state_d == ST_ADJUST && state_q != ST_ADJUST) begin
            blink_d = 1'b1;
        end

        if (state_d == ST_ADJUST) begin
            show_mask_d = sw_sel ? {1'b1, blink_d} : {blink_d, 1'b1};
        end
    end

    // State, button history, blink and mask registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            btn_pause_q <= 1'b1;
            btn_clear_q <= 1'b1;
            blink_q     <= 1'b1;
            show_mask_q <= 2'b11;
        end else begin
            state_q     <= state_d;
            btn_pause_q <= btn_pause;
            btn_clear_q <= btn_clear;
            blink_q     <= blink_d;
            show_mask_q <= show_mask_d;
        end
    end

    bcd60_counter #(.MAX(SEC_MAX)) u_sec (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear_edge),
        .inc       (sec_inc),
        .tens      (sec_tens),
        .ones      (sec_ones),
        .carry_out (sec_carry)
    );

    logic min_carry_unused;

    bcd60_counter #(.MAX(MIN_MAX)) u_min (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear_edge),
        .inc       (min_inc),
        .tens      (min_tens),
        .ones      (min_ones),
        .carry_out (min_carry_unused)
    );

    assign state     = state_q;
    assign show_mask = show_mask_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, tick_2hz, tick_5hz;
    logic       btn_pause, btn_clear, sw_adj, sw_sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] state, show_mask;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .tick_5hz  (tick_5hz),
        .btn_pause (btn_pause),
        .btn_clear (btn_clear),
        .sw_adj    (sw_adj),
        .sw_sel    (sw_sel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .state     (state),
        .show_mask (show_mask)
    );

    // Advance one clock, sample 1 ns later, and drop single-cycle pulses.
    task automatic cyc();
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        tick_5hz = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] tm();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    initial begin
        rst = 1'b1; tick_1hz = 0; tick_2hz = 0; tick_5hz = 0;
        btn_pause = 0; btn_clear = 0; sw_adj = 0; sw_sel = 0;

        // Reset values
        cyc(); cyc();
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_time", tm(), 16'h0000);
        chk("rst_mask", 16'(show_mask), 16'd3);
        rst = 1'b0;
        cyc();

        // Start, then 61 seconds -> 01:01
        btn_pause = 1; cyc();
        chk("start_run", 16'(state), 16'd1);
        btn_pause = 0; cyc();
        for (int i = 0; i < 61; i++) begin tick_1hz = 1; cyc(); end
        chk("run61_time", tm(), 16'h0101);
        chk("run61_state", 16'(state), 16'd1);

        // Held button gives a single edge
        btn_pause = 1; cyc(); cyc(); cyc();
        chk("hold_pause", 16'(state), 16'd2);
        tick_1hz = 1; cyc();
        chk("pause_hold_time", tm(), 16'h0101);
        btn_pause = 0; cyc();
        btn_pause = 1; cyc();
        chk("resume_run", 16'(state), 16'd1);
        btn_pause = 0; cyc();

        // Clear with adjust switch on -> ADJUST, zeroed
        sw_adj = 1; btn_clear = 1; cyc();
        chk("clr_adj_state", 16'(state), 16'd3);
        chk("clr_adj_time", tm(), 16'h0000);
        chk("adj_entry_mask", 16'(show_mask), 16'd3);
        btn_clear = 0;

        // Preset 59:59 via adjust, checking field wrap without carry
        sw_sel = 0;
        for (int i = 0; i < 59; i++) begin tick_5hz = 1; cyc(); end
        chk("adj_min59", tm(), 16'h5900);
        sw_sel = 1;
        for (int i = 0; i < 60; i++) begin tick_5hz = 1; cyc(); end
        chk("adj_sec_wrap", tm(), 16'h5900);
        for (int i = 0; i < 59; i++) begin tick_5hz = 1; cyc(); end
        chk("adj_5959", tm(), 16'h5959);
        sw_adj = 0; cyc();
        chk("adj_exit_pause", 16'(state), 16'd2);
        btn_pause = 1; cyc();
        btn_pause = 0;
        chk("run_again", 16'(state), 16'd1);
        tick_1hz = 1; cyc();
        chk("wrap_0000", tm(), 16'h0000);

        // Tick and pause in the same cycle
        for (int i = 0; i < 5; i++) begin tick_1hz = 1; cyc(); end
        chk("run_0005", tm(), 16'h0005);
        tick_1hz = 1; btn_pause = 1; cyc();
        chk("tickpause_time", tm(), 16'h0006);
        chk("tickpause_state", 16'(state), 16'd2);
        btn_pause = 0;
        for (int i = 0; i < 3; i++) begin tick_1hz = 1; cyc(); end
        chk("pause_held", tm(), 16'h0006);

        // Adjust: minutes to 03, then 62 second ticks -> 03:02
        sw_adj = 1; sw_sel = 1; cyc();
        btn_clear = 1; cyc();
        btn_clear = 0;
        chk("adj_clr_time", tm(), 16'h0000);
        sw_sel = 0;
        for (int i = 0; i < 3; i++) begin tick_5hz = 1; cyc(); end
        sw_sel = 1;
        for (int i = 0; i < 62; i++) begin tick_5hz = 1; cyc(); end
        chk("adj_sec62", tm(), 16'h0302);
        tick_1hz = 1; btn_pause = 1; cyc();
        btn_pause = 0;
        chk("adj_ign_time", tm(), 16'h0302);
        chk("adj_ign_state", 16'(state), 16'd3);
        chk("mask_pre_blink", 16'(show_mask), 16'd3);
        tick_2hz = 1; cyc();
        chk("mask_blink1", 16'(show_mask), 16'd2);
        tick_2hz = 1; cyc();
        chk("mask_blink2", 16'(show_mask), 16'd3);
        sw_sel = 0; tick_2hz = 1; cyc();
        chk("mask_min_blink", 16'(show_mask), 16'd1);

        // Preset 12:34 and clear during a tick in RUN
        btn_clear = 1; cyc();
        btn_clear = 0;
        for (int i = 0; i < 12; i++) begin tick_5hz = 1; cyc(); end
        sw_sel = 1;
        for (int i = 0; i < 34; i++) begin tick_5hz = 1; cyc(); end
        chk("preset_1234", tm(), 16'h1234);
        sw_adj = 0; cyc();
        chk("exit_mask", 16'(show_mask), 16'd3);
        btn_pause = 1; cyc();
        btn_pause = 0;
        chk("run_1234", 16'(state), 16'd1);
        btn_clear = 1; tick_1hz = 1; cyc();
        btn_clear = 0;
        chk("clr_run_time", tm(), 16'h0000);
        chk("clr_run_state", 16'(state), 16'd0);

        // Button held through reset release gives no edge
        btn_pause = 1; rst = 1; cyc(); cyc();
        rst = 0; cyc(); cyc();
        chk("held_rst_state", 16'(state), 16'd0);
        btn_pause = 0; cyc();
        btn_pause = 1; cyc();
        chk("press_after_rst", 16'(state), 16'd1);
        btn_pause = 0; cyc();

        // Reset in mid-adjust
        sw_adj = 1; cyc();
        tick_5hz = 1; tick_2hz = 1; cyc();
        chk("adj_before_rst", tm(), 16'h0001);
        rst = 1; tick_5hz = 1; cyc();
        chk("midadj_rst_state", 16'(state), 16'd0);
        chk("midadj_rst_time", tm(), 16'h0000);
        chk("midadj_rst_mask", 16'(show_mask), 16'd3);
        rst = 0; sw_adj = 0; cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard bound on runtime.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- tick_1hz, input, 1: single-cycle count pulse from the clock divider.
- tick_2hz, input, 1: single-cycle blink pulse from the clock divider.
- tick_5hz, input, 1: single-cycle adjust-rate pulse from the clock divider.
- btn_pause, input, 1: debounced pause/run button level.
- btn_clear, input, 1: debounced clear button level.
- sw_adj, input, 1: adjust-mode switch level.
- sw_sel, input, 1: adjust field select; 0 = minutes, 1 = seconds.
- min_tens, output, 4: minutes tens digit, BCD, 0..5.
- min_ones, output, 4: minutes ones digit, BCD, 0..9.
- sec_tens, output, 4: seconds tens digit, BCD, 0..5.
- sec_ones, output, 4: seconds ones digit, BCD, 0..9.
- state, output, 2: FSM state; IDLE=0, RUN=1, PAUSE=2, ADJUST=3.
- show_mask, output, 2: display visibility; bit1 = minutes, bit0 = seconds; 1 = visible.

Function
REQ-002 Every output SHALL be a register, updated only on the rising edge of clk.
REQ-003 Button edges SHALL be defined as pause_edge = btn_pause & ~btn_pause_q and clear_edge = btn_clear & ~btn_clear_q, where btn_pause_q and btn_clear_q are one-cycle-delayed copies of the button inputs.
REQ-004 An edge SHALL take effect at the clock edge where the level is first sampled high; holding a button SHALL produce exactly one edge.
REQ-005 State transitions in IDLE:
- pause_edge SHALL go to RUN.
- sw_adj=1 SHALL go to ADJUST and SHALL take priority over pause_edge.
REQ-006 State transitions in RUN:
- tick_1hz SHALL increment the time by one second.
- pause_edge SHALL go to PAUSE.
- sw_adj=1 SHALL go to ADJUST; tick_1hz SHALL be discarded in that cycle.
REQ-007 In RUN, when tick_1hz and pause_edge occur in the same cycle, the increment SHALL be applied and the next state SHALL be PAUSE.
REQ-008 State transitions in PAUSE:
- pause_edge SHALL go to RUN.
- sw_adj=1 SHALL go to ADJUST and SHALL take priority over pause_edge.
- The time SHALL be held.
REQ-009 State transitions in ADJUST:
- sw_adj=0 SHALL go to PAUSE.
- pause_edge SHALL be ignored.
- tick_1hz SHALL be ignored.
REQ-010 In ADJUST, each tick_5hz SHALL increment only the selected field, by one:
- sw_sel=0: minutes.
- sw_sel=1: seconds.
REQ-011 In ADJUST, seconds SHALL wrap 59->00 with no carry into minutes, and minutes SHALL wrap 59->00.
REQ-012 The RUN increment SHALL count seconds x9->(x+1)0 and 59->00 with a carry into minutes, and SHALL wrap the time 59:59->00:00.
REQ-013 The digits SHALL never hold a value outside their legal BCD range.
REQ-014 In any state, clear_edge SHALL:
- zero all four digits;
- set the next state to ADJUST if sw_adj=1, otherwise IDLE;
- override pause_edge and every tick in that cycle.
REQ-015 show_mask SHALL be 2'b11 in IDLE, RUN and PAUSE.
REQ-016 In ADJUST, an internal blink flag SHALL toggle on each tick_2hz.
REQ-017 In ADJUST, the selected field's mask bit SHALL equal the blink flag and the other bit SHALL be 1.
REQ-018 The blink flag SHALL be set to 1 on entry to ADJUST.
REQ-019 Updates SHALL have one-cycle latency: an event sampled at edge n SHALL be visible on the outputs after edge n.

Reset
REQ-020 While rst=1, the block SHALL set state=IDLE, all digits=0, show_mask=2'b11, blink flag=1, and btn_pause_q=btn_clear_q=1.
REQ-021 Because the delayed button copies reset to 1, a button held through reset SHALL produce no edge.
REQ-022 rst SHALL override all inputs, including in mid-operation and in mid-ADJUST.

Structure
REQ-023 Package stopwatch_pkg SHALL hold the state encoding type and the constants SEC_MAX=59, MIN_MAX=59 and the BCD digit width (4).
REQ-024 Sub-module bcd60_counter (a 00..59 BCD counter with clr, inc, carry_out) SHALL be instantiated twice, once for seconds and once for minutes.
REQ-025 In ADJUST, the seconds counter's carry_out SHALL be gated off so that it does not reach the minutes counter.

Verification
REQ-026 Reset, pause_edge, then 61 tick_1hz pulses -> state=RUN, time 01:01.
REQ-027 Time preset to 59:59 in RUN, one tick_1hz -> 00:00.
REQ-028 RUN with tick_1hz and pause_edge in the same cycle at 00:05 -> 00:06, state=PAUSE; further ticks -> time held.
REQ-029 sw_adj=1, sw_sel=1, 62 tick_5hz pulses -> seconds=02, minutes unchanged; two tick_2hz pulses -> show_mask 10 then 11.
REQ-030 clear_edge together with tick_1hz in RUN at 12:34 -> 00:00, state=IDLE; clear_edge with sw_adj=1 -> state=ADJUST.
REQ-031 btn_pause held high across the release of rst -> state stays IDLE; release then press -> RUN.
